// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: requests one BCD conversion per display frame and scans the low DIGITS digits onto a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [39:0]       bcd,
  input  logic              conv_idle,
  output logic              conv_trigger,
  output logic [DIGITS-1:0] anodes,
  output logic [6:0]        segments,
  output logic              ovf
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  // Digits beyond the display width; all-zero when every digit is displayed
  localparam logic [39:0] HI_MASK = ~({40{1'b1}} >> (40 - 4 * DIGITS));
  typedef enum logic [1:0] {S_READY, S_PEND, S_START, S_BUSY} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [39:0] disp;
  logic [5:0] base;
  logic [3:0] nib;
  logic [6:0] seg_n;
  logic tick, frame_tick, trig_n, capture, blank;
  assign tick = presc == PW'(REFRESH_DIV - 1);
  assign frame_tick = tick && idx == IW'(DIGITS - 1);
  assign base = 6'(idx) << 2;
  assign nib = disp[base +: 4];
`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS:0] lead;
  logic [DIGITS-1:0] nz_up;
  // lead[i]: digit i or any higher displayed digit is nonzero
  always_comb begin
    lead = '0;
    for (int i = DIGITS - 1; i >= 0; i--) lead[i] = (disp[4*i +: 4] != 4'd0) | lead[i+1];
  end
  assign nz_up = lead[DIGITS-1:0];
  assign blank = idx != '0 && !nz_up[idx];
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    seg_n = 7'h3F;
    case (nib)
      4'd0: seg_n = 7'h40;
      4'd1: seg_n = 7'h79;
      4'd2: seg_n = 7'h24;
      4'd3: seg_n = 7'h30;
      4'd4: seg_n = 7'h19;
      4'd5: seg_n = 7'h12;
      4'd6: seg_n = 7'h02;
      4'd7: seg_n = 7'h78;
      4'd8: seg_n = 7'h00;
      4'd9: seg_n = 7'h10;
      default: seg_n = 7'h3F;
    endcase
    if (blank) seg_n = 7'h7F;
  end
  always_comb begin
    state_n = state;
    trig_n = 1'b0;
    capture = 1'b0;
    case (state)
      S_READY: if (frame_tick) begin
        trig_n = conv_idle;
        state_n = conv_idle ? S_START : S_PEND;
      end
      S_PEND: if (conv_idle) begin
        trig_n = 1'b1;
        state_n = S_START;
      end
      S_START: if (!conv_idle) state_n = S_BUSY;
      S_BUSY: if (conv_idle) begin
        capture = 1'b1;
        state_n = S_READY;
      end
      default: state_n = S_READY;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_READY;
      presc <= '0;
      idx <= '0;
      disp <= '0;
      conv_trigger <= 1'b0;
      anodes <= '1;
      segments <= 7'h7F;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      conv_trigger <= trig_n;
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      if (capture) begin
        disp <= bcd;
        ovf <= |(bcd & HI_MASK);
      end
      anodes <= ~(DIGITS'(1) << idx);
      segments <= seg_n;
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed bench with a simple converter model (DIGITS=8, REFRESH_DIV=4).
module tb_bcd_display_scanner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [39:0] conv_val = '0;
  logic conv_idle = 1'b1;
  logic conv_trigger;
  logic [7:0] anodes;
  logic [6:0] segments;
  logic ovf;
  logic hold = 1'b0;
  logic prev_trig = 1'b0;
  int checks = 0;
  int failures = 0;
  int cnt = 0;
  int trig_cnt = 0;
  logic [6:0] e[8];
  always #5 clk = ~clk;
  bcd_display_scanner #(.DIGITS(8), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .bcd(conv_val), .conv_idle(conv_idle),
    .conv_trigger(conv_trigger), .anodes(anodes), .segments(segments), .ovf(ovf)
  );
  // Converter model: drops idle for 5 cycles after each trigger; hold forces it busy
  always @(negedge clk) begin
    if (conv_trigger) begin
      checks++;
      assert (prev_trig === 1'b0) else begin
        failures++;
        $error("FAIL trig_width observed=%b expected=0", prev_trig);
      end
      trig_cnt++;
    end
    prev_trig = conv_trigger;
    if (conv_trigger) cnt = 5;
    else if (cnt > 0) cnt--;
    conv_idle = cnt == 0 && !hold;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_capture();
    int n = 0;
    while (conv_trigger !== 1'b1 && n < 200) begin step(); n++; end
    check("trig_seen", conv_trigger, 1);
    n = 0;
    step();
    while (conv_idle !== 1'b1 && n < 50) begin step(); n++; end
    check("idle_return", conv_idle, 1);
    step();
  endtask
  task automatic sync_frame(input string tag);
    int n = 0;
    logic [7:0] pa;
    pa = anodes;
    step();
    while (!(anodes == 8'hFE && pa == 8'h7F) && n < 100) begin pa = anodes; step(); n++; end
    check({tag, "_sync"}, n < 100, 1);
  endtask
  task automatic check_scan(input string tag);
    logic [7:0] an_exp;
    sync_frame(tag);
    for (int s = 0; s < 8; s++) begin
      an_exp = ~(8'd1 << s);
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s_an%0d", tag, s), anodes, an_exp);
        check($sformatf("%s_seg%0d", tag, s), segments, e[s]);
        step();
      end
    end
    check({tag, "_wrap"}, anodes, 8'hFE);
  endtask
  initial begin
    int n;
    conv_val = {$urandom, $urandom};
    repeat (3) step();
    check("rst_an", anodes, 8'hFF);
    check("rst_seg", segments, 7'h7F);
    check("rst_trig", conv_trigger, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rel_an", anodes, 8'hFE);
    check("rel_seg", segments, 7'h40);
    conv_val = 40'h0012345678;
    wait_capture();
    check("ovf_small", ovf, 0);
    e = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    check_scan("scan");
    trig_cnt = 0;
    repeat (64) step();
    check("trig_per_2frames", trig_cnt, 2);
    conv_val = 40'h1234567890;
    wait_capture();
    check("ovf_big", ovf, 1);
    e = '{7'h40, 7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30};
    check_scan("ovf");
    wait_capture();
    @(posedge clk);
    #1;
    hold = 1'b1;
    conv_val = 40'h000000000A;
    sync_frame("busy");
    for (int i = 0; i < 10; i++) begin
      check("busy_no_trig", conv_trigger, 0);
      step();
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    step();
    check("busy_trig_early", conv_trigger, 0);
    step();
    check("busy_trig", conv_trigger, 1);
    n = 0;
    step();
    while (conv_idle !== 1'b1 && n < 50) begin step(); n++; end
    check("busy_idle_return", conv_idle, 1);
    step();
    check("ovf_dash", ovf, 0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    e = '{7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    e = '{7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
    check_scan("dash");
    conv_val = 40'h42;
    wait_capture();
    check("ovf_42", ovf, 0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    e = '{7'h24, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    e = '{7'h24, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
    check_scan("blank42");
    conv_val = 40'h0;
    wait_capture();
`ifdef BCD_LEADING_ZERO_BLANK_EN
    e = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    e = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
    check_scan("zero");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
